// File: rtl/systolic_array_pkg.sv
// Shared types and helpers for the output-stationary systolic multiplier.
package systolic_array_pkg;

  // Job sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } sa_state_t;

  // Default accumulator width: full product plus headroom for k_depth additions
  function automatic int unsigned sa_acc_width(input int unsigned dw, input int unsigned k);
    return 2 * dw + $clog2(k);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Single output-stationary processing element: forwards operands/tag one hop per cycle
// and accumulates the product whenever the tag marks a real beat.
module systolic_pe
  import systolic_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_signed_mode,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_tag,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic                  o_tag,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_tag;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ProdW-1:0]      w_a_ext;
  logic [ProdW-1:0]      w_b_ext;
  logic [ProdW-1:0]      w_prod;
  logic [ACC_WIDTH-1:0]  w_prod_ext;

  // Extend operands to product width; the low ProdW bits are then exact in either mode
  always_comb begin
    w_a_ext = {{DATA_WIDTH{i_signed_mode & i_a[DATA_WIDTH-1]}}, i_a};
    w_b_ext = {{DATA_WIDTH{i_signed_mode & i_b[DATA_WIDTH-1]}}, i_b};
    w_prod  = w_a_ext * w_b_ext;
  end

  if (ACC_WIDTH > ProdW) begin : g_ext
    assign w_prod_ext = {{(ACC_WIDTH - ProdW){i_signed_mode & w_prod[ProdW-1]}}, w_prod};
  end else begin : g_trunc
    // Narrow accumulator simply wraps
    assign w_prod_ext = w_prod[ACC_WIDTH-1:0];
  end

  // Operand forwarding and accumulation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_tag <= 1'b0;
      r_acc <= '0;
    end else begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_tag <= i_tag;
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_tag) begin
        r_acc <= r_acc + w_prod_ext;
      end
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_tag = r_tag;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary systolic matrix multiplier: takes one A column and one B row per beat,
// skews them into a ROWS x COLS PE grid, then streams C out one row per handshake.
module systolic_array_os
  import systolic_array_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned K_DEPTH    = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = sa_acc_width(DATA_WIDTH, K_DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_signed_mode,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] i_in_a_col,
  input  logic [COLS*DATA_WIDTH-1:0] i_in_b_row,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [COLS*ACC_WIDTH-1:0]  o_out_data,
  output logic [$clog2(ROWS):0]      o_out_row,
  output logic                       o_out_last,
  output logic                       o_busy
);

  localparam int unsigned BeatW  = $clog2(K_DEPTH + 1);
  localparam int unsigned DrainW = $clog2(ROWS + COLS);
  localparam int unsigned RowW   = $clog2(ROWS) + 1;

  sa_state_t         r_state, w_state_d;
  logic [BeatW-1:0]  r_beat_cnt, w_beat_d;
  logic [DrainW-1:0] r_drain_cnt, w_drain_d;
  logic [RowW-1:0]   r_out_row, w_row_d;
  logic              r_signed, w_signed_d;
  logic              w_clr;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_pe_signed;

  logic [DATA_WIDTH-1:0] w_a_grid [ROWS][COLS+1];
  logic                  w_t_grid [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] w_b_grid [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  w_acc    [ROWS][COLS];

  assign w_accept = i_in_valid & w_in_ready;
  // The first beat multiplies in PE(0,0) on its accept edge, before the latch has updated
  assign w_pe_signed = (r_state == IDLE) ? i_signed_mode : r_signed;

  // Next-state, counters and handshake outputs
  always_comb begin
    w_state_d   = r_state;
    w_beat_d    = r_beat_cnt;
    w_drain_d   = r_drain_cnt;
    w_row_d     = r_out_row;
    w_signed_d  = r_signed;
    w_clr       = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) begin
          w_signed_d = i_signed_mode;
          w_beat_d   = BeatW'(1);
          w_drain_d  = '0;
          w_state_d  = (K_DEPTH == 1) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        w_in_ready = 1'b1;
        if (i_in_valid) begin
          w_beat_d = r_beat_cnt + BeatW'(1);
          if (r_beat_cnt == BeatW'(K_DEPTH - 1)) begin
            w_state_d = DRAIN;
            w_drain_d = '0;
          end
        end
      end
      DRAIN: begin
        w_drain_d = r_drain_cnt + DrainW'(1);
        // Wait until the last beat has crossed to the far corner PE
        if (r_drain_cnt == DrainW'(ROWS + COLS - 2)) begin
          w_state_d = OUTPUT;
          w_row_d   = '0;
        end
      end
      OUTPUT: begin
        w_out_valid = 1'b1;
        if (i_out_ready) begin
          if (r_out_row == RowW'(ROWS - 1)) begin
            w_state_d = IDLE;
            w_row_d   = '0;
            w_clr     = 1'b1;
          end else begin
            w_row_d = r_out_row + RowW'(1);
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_out_row   <= '0;
      r_signed    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_beat_cnt  <= w_beat_d;
      r_drain_cnt <= w_drain_d;
      r_out_row   <= w_row_d;
      r_signed    <= w_signed_d;
    end
  end

  // A skew: row r is delayed r cycles before entering column 0
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign w_a_grid[r][0] = i_in_a_col[0 +: DATA_WIDTH];
      assign w_t_grid[r][0] = w_accept;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] r_a_sh [r];
      logic                  r_t_sh [r];
      // Shift operand and tag together
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < r; i++) begin
            r_a_sh[i] <= '0;
            r_t_sh[i] <= 1'b0;
          end
        end else begin
          r_a_sh[0] <= i_in_a_col[r*DATA_WIDTH +: DATA_WIDTH];
          r_t_sh[0] <= w_accept;
          for (int i = 1; i < r; i++) begin
            r_a_sh[i] <= r_a_sh[i-1];
            r_t_sh[i] <= r_t_sh[i-1];
          end
        end
      end
      assign w_a_grid[r][0] = r_a_sh[r-1];
      assign w_t_grid[r][0] = r_t_sh[r-1];
    end
  end

  // B skew: column c is delayed c cycles before entering row 0
  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    if (c == 0) begin : g_direct
      assign w_b_grid[0][c] = i_in_b_row[0 +: DATA_WIDTH];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] r_b_sh [c];
      // Plain operand delay line; the tag rides with A
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < c; i++) begin
            r_b_sh[i] <= '0;
          end
        end else begin
          r_b_sh[0] <= i_in_b_row[c*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < c; i++) begin
            r_b_sh[i] <= r_b_sh[i-1];
          end
        end
      end
      assign w_b_grid[0][c] = r_b_sh[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clr         (w_clr),
        .i_signed_mode (w_pe_signed),
        .i_a           (w_a_grid[r][c]),
        .i_b           (w_b_grid[r][c]),
        .i_tag         (w_t_grid[r][c]),
        .o_a           (w_a_grid[r][c+1]),
        .o_b           (w_b_grid[r+1][c]),
        .o_tag         (w_t_grid[r][c+1]),
        .o_acc         (w_acc[r][c])
      );
    end
    // Operands falling off the right edge go nowhere
    logic w_unused_right;
    assign w_unused_right = ^{w_a_grid[r][COLS], w_t_grid[r][COLS]};
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bottom
    logic w_unused_bottom;
    assign w_unused_bottom = ^w_b_grid[ROWS][c];
  end

  // Result row select
  always_comb begin
    o_out_data = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (r_out_row == RowW'(r)) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          o_out_data[c*ACC_WIDTH +: ACC_WIDTH] = w_acc[r][c];
        end
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_row   = r_out_row;
  assign o_out_last  = w_out_valid && (r_out_row == RowW'(ROWS - 1));
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_systolic_array_os.sv
// Randomised bench for systolic_array_os: a 4x4x8 instance checked against a plain
// matrix-product model, plus a 2x2x2 instance with a 16-bit accumulator for fixed cases.
module tb_systolic_array_os;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int K   = 8;
  localparam int DW  = 8;
  localparam int AW  = 19;
  localparam int SAW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              signed_mode, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [R*DW-1:0]   a_col;
  logic [C*DW-1:0]   b_row;
  logic [C*AW-1:0]   out_data;
  logic [$clog2(R):0] out_row;

  logic              s_signed_mode, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic              s_out_last, s_busy;
  logic [2*DW-1:0]   s_a_col, s_b_row;
  logic [2*SAW-1:0]  s_out_data;
  logic [1:0]        s_out_row;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] cur_a [R][K];
  logic [DW-1:0] cur_b [K][C];
  logic [DW-1:0] nxt_a [R][K];
  logic [DW-1:0] nxt_b [K][C];
  longint        exp_c [R][C];
  logic [DW-1:0] s_a   [2][2];
  logic [DW-1:0] s_b   [2][2];
  longint        s_exp [2][2];

  systolic_array_os #(
    .ROWS(R), .COLS(C), .K_DEPTH(K), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_signed_mode(signed_mode), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_in_a_col(a_col), .i_in_b_row(b_row), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_out_row(out_row),
    .o_out_last(out_last), .o_busy(busy)
  );

  systolic_array_os #(
    .ROWS(2), .COLS(2), .K_DEPTH(2), .DATA_WIDTH(DW), .ACC_WIDTH(SAW)
  ) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_signed_mode(s_signed_mode), .i_in_valid(s_in_valid),
    .o_in_ready(s_in_ready), .i_in_a_col(s_a_col), .i_in_b_row(s_b_row),
    .o_out_valid(s_out_valid), .i_out_ready(s_out_ready), .o_out_data(s_out_data),
    .o_out_row(s_out_row), .o_out_last(s_out_last), .o_busy(s_busy)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ext(input logic [DW-1:0] v, input bit sm);
    return sm ? longint'($signed(v)) : longint'(v);
  endfunction

  // C = A * B modulo 2^AW
  task automatic compute_expected(input bit sm);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        longint s = 0;
        for (int k = 0; k < K; k++) s += ext(cur_a[r][k], sm) * ext(cur_b[k][c], sm);
        exp_c[r][c] = s & ((longint'(1) << AW) - 1);
      end
    end
  endtask

  // mode 0 random, 1 all -128, 2 A=-1 and B=1
  task automatic gen_next(input int mode);
    for (int r = 0; r < R; r++)
      for (int k = 0; k < K; k++)
        nxt_a[r][k] = (mode == 1) ? 8'h80 : (mode == 2) ? 8'hFF : 8'($urandom);
    for (int k = 0; k < K; k++)
      for (int c = 0; c < C; c++)
        nxt_b[k][c] = (mode == 1) ? 8'h80 : (mode == 2) ? 8'h01 : 8'($urandom);
  endtask

  task automatic copy_next();
    cur_a = nxt_a;
    cur_b = nxt_b;
  endtask

  task automatic drive_beats(input bit sm, input bit bubbles);
    int n;
    for (int k = 0; k < K; k++) begin
      int nb = bubbles ? $urandom_range(2, 0) : 0;
      for (int i = 0; i < nb; i++) begin
        in_valid    = 1'b0;
        signed_mode = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
      end
      // Only the first beat's mode should matter
      signed_mode = (k == 0) ? sm : 1'($urandom_range(1, 0));
      in_valid    = 1'b1;
      for (int r = 0; r < R; r++) a_col[r*DW +: DW] = cur_a[r][k];
      for (int c = 0; c < C; c++) b_row[c*DW +: DW] = cur_b[k][c];
      n = 0;
      while (!in_ready && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 64) check_eq("in_ready_timeout", n, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_job(input bit sm, input bit bubbles, input bit stalls, input bit preoffer,
                        input bit nsm);
    int lat;
    int n;
    logic [C*AW-1:0] held;
    compute_expected(sm);
    drive_beats(sm, bubbles);
    check_eq("in_ready_drain", in_ready, 0);
    check_eq("busy_drain", busy, 1);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, R + C);
    for (int r = 0; r < R; r++) begin
      n = 0;
      while (!out_valid && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      if (preoffer) begin
        in_valid    = 1'b1;
        signed_mode = nsm;
        for (int i = 0; i < R; i++) a_col[i*DW +: DW] = nxt_a[i][0];
        for (int c = 0; c < C; c++) b_row[c*DW +: DW] = nxt_b[0][c];
        check_eq("in_ready_output", in_ready, 0);
      end
      if (stalls) begin
        int ns = $urandom_range(3, 0);
        out_ready = 1'b0;
        held = out_data;
        for (int s = 0; s < ns; s++) begin
          @(posedge clk); #1;
          check_eq("stall_valid", out_valid, 1);
          check_eq("stall_stable", (out_data === held && out_row == r) ? 1 : 0, 1);
        end
      end
      out_ready = 1'b1;
      for (int c = 0; c < C; c++)
        check_eq($sformatf("C[%0d][%0d]", r, c), out_data[c*AW +: AW], exp_c[r][c]);
      check_eq("out_row", out_row, r);
      check_eq("out_last", out_last, (r == R - 1) ? 1 : 0);
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    if (!preoffer) begin
      check_eq("idle_busy", busy, 0);
      check_eq("idle_in_ready", in_ready, 1);
    end else begin
      check_eq("b2b_in_ready_idle", in_ready, 1);
    end
  endtask

  task automatic small_job(input bit sm, input string name);
    int n;
    int lat;
    s_signed_mode = sm;
    for (int k = 0; k < 2; k++) begin
      s_in_valid = 1'b1;
      s_a_col    = {s_a[1][k], s_a[0][k]};
      s_b_row    = {s_b[k][1], s_b[k][0]};
      n = 0;
      while (!s_in_ready && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 64) check_eq({name, "_in_ready_timeout"}, n, 0);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({name, "_latency"}, lat, 4);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++)
        check_eq($sformatf("%s_C[%0d][%0d]", name, r, c), s_out_data[c*SAW +: SAW],
                 s_exp[r][c]);
      check_eq({name, "_row"}, s_out_row, r);
      check_eq({name, "_last"}, s_out_last, r);
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
    end
    check_eq({name, "_busy_end"}, s_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    signed_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_col = '0; b_row = '0;
    s_signed_mode = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_a_col = '0; s_b_row = '0;
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_row", out_row, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data_zero", (out_data == '0) ? 1 : 0, 1);
    #8 rst_n = 1'b1;
    @(posedge clk); #1;

    // 2x2x2 unsigned reference case
    s_a = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    s_b = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
    s_exp = '{'{19, 22}, '{43, 50}};
    small_job(1'b0, "small");
    // 16-bit accumulator wraps: 2*255*255 mod 65536
    s_a = '{'{8'd255, 8'd255}, '{8'd255, 8'd255}};
    s_b = '{'{8'd255, 8'd255}, '{8'd255, 8'd255}};
    s_exp = '{'{64514, 64514}, '{64514, 64514}};
    small_job(1'b0, "wrap");

    // Signed extremes
    gen_next(1); copy_next();
    do_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    gen_next(2); copy_next();
    do_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random jobs with bubbles and output stalls
    for (int j = 0; j < 6; j++) begin
      gen_next(0); copy_next();
      do_job(1'($urandom_range(1, 0)), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Reset while draining, then a fresh job must see clean accumulators
    gen_next(0); copy_next();
    drive_beats(1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_busy", busy, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    gen_next(0); copy_next();
    do_job(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back: second job offered while the first is still streaming out
    gen_next(0); copy_next();
    gen_next(0);
    do_job(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    copy_next();
    do_job(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
